// File: rtl/axi_st_crc_pkg.sv
// Shared definitions for the AXI-Stream CRC strip/insert blocks:
// FSM states, CRC byte count and a tkeep popcount helper.
package axi_st_crc_pkg;

   localparam int unsigned CRC_BYTES = 4;
   localparam int unsigned KEEP_MAX  = 128;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_HOLD,
      ST_TAIL
   } crc_state_e;

   // Number of set bits in a tkeep vector (zero-extended to KEEP_MAX by the caller)
   function automatic int unsigned keep_count(input logic [KEEP_MAX-1:0] keep);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < KEEP_MAX; i++) begin
         if (keep[i]) cnt++;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/axi_stream_crc_strip.sv
// Removes the trailing CRC from AXI-Stream frames through a one-beat holding
// buffer, presenting the extracted CRC alongside the frame's last output beat.
module axi_stream_crc_strip
   import axi_st_crc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_BYTES = DATA_WIDTH / 8,
   parameter int unsigned CRC_WIDTH  = 8 * CRC_BYTES
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [DATA_WIDTH-1:0] i_s_tdata,
   input  logic [KEEP_BYTES-1:0] i_s_tkeep,
   input  logic                  i_s_tlast,
   input  logic                  i_s_tvalid,
   output logic                  o_s_tready,
   output logic [DATA_WIDTH-1:0] o_m_tdata,
   output logic [KEEP_BYTES-1:0] o_m_tkeep,
   output logic                  o_m_tlast,
   output logic                  o_m_tvalid,
   input  logic                  i_m_tready,
   output logic [CRC_WIDTH-1:0]  o_crc,
   output logic                  o_crc_valid,
   output logic                  o_runt
);

   localparam int unsigned CB = CRC_WIDTH / 8;

   function automatic logic [KEEP_BYTES-1:0] low_mask(input int unsigned cnt);
      logic [KEEP_BYTES-1:0] m;
      for (int unsigned i = 0; i < KEEP_BYTES; i++) m[i] = (i < cnt);
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [KEEP_BYTES-1:0] k);
      logic [DATA_WIDTH-1:0] r;
      for (int unsigned i = 0; i < KEEP_BYTES; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
      return r;
   endfunction

   crc_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0]  buf_data_q, buf_data_d;
   logic [KEEP_BYTES-1:0]  buf_keep_q, buf_keep_d;
   logic [CRC_WIDTH-1:0]   crc_q, crc_d;
   logic                   runt_q, runt_d;

   int unsigned            in_count;
   int unsigned            pad;
   logic                   short_last;
   logic [KEEP_BYTES-1:0]  trim_keep, merge_keep;
   logic [CRC_WIDTH-1:0]   trim_crc, merge_crc;
   logic                   in_ready, out_valid, out_last;
   logic [KEEP_BYTES-1:0]  out_keep;
   logic [CRC_WIDTH-1:0]   out_crc;

   // Trim/merge candidates for an incoming last beat; pad = CRC bytes owed by the buffered beat
   always_comb begin
      in_count   = keep_count(KEEP_MAX'(i_s_tkeep));
      short_last = i_s_tlast && (in_count <= CB);
      pad        = short_last ? (CB - in_count) : 0;
      trim_keep  = short_last ? '0 : low_mask(in_count - CB);
      trim_crc   = short_last ? '0 : CRC_WIDTH'(i_s_tdata >> (8 * (in_count - CB)));
      merge_keep = buf_keep_q & low_mask(KEEP_BYTES - pad);
      merge_crc  = CRC_WIDTH'(buf_data_q >> (8 * (KEEP_BYTES - pad)))
                 | (CRC_WIDTH'(i_s_tdata) << (8 * pad));
   end

   always_comb begin
      state_d    = state_q;
      buf_data_d = buf_data_q;
      buf_keep_d = buf_keep_q;
      crc_d      = crc_q;
      runt_d     = 1'b0;
      in_ready   = 1'b1;
      out_valid  = 1'b0;
      out_keep   = buf_keep_q;
      out_last   = 1'b0;
      out_crc    = crc_q;

      case (state_q)
         ST_EMPTY: ;
         ST_HOLD: begin
            in_ready  = i_m_tready;
            out_valid = i_s_tvalid;
            if (i_s_tvalid && short_last) begin
               out_keep = merge_keep;
               out_last = 1'b1;
               out_crc  = merge_crc;
            end
         end
         ST_TAIL: begin
            in_ready  = i_m_tready;
            out_valid = 1'b1;
            out_last  = 1'b1;
            if (i_m_tready) begin
               state_d    = ST_EMPTY;
               buf_keep_d = '0;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Accepted input beat; a short last beat either merges into the held beat or is a runt
      if (i_s_tvalid && in_ready) begin
         if (!i_s_tlast) begin
            buf_data_d = i_s_tdata;
            buf_keep_d = i_s_tkeep;
            state_d    = ST_HOLD;
         end else if (!short_last) begin
            buf_data_d = i_s_tdata;
            buf_keep_d = trim_keep;
            crc_d      = trim_crc;
            state_d    = ST_TAIL;
         end else begin
            buf_keep_d = '0;
            state_d    = ST_EMPTY;
            runt_d     = (state_q != ST_HOLD);
         end
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state_q    <= ST_EMPTY;
         buf_data_q <= '0;
         buf_keep_q <= '0;
         crc_q      <= '0;
         runt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_data_q <= buf_data_d;
         buf_keep_q <= buf_keep_d;
         crc_q      <= crc_d;
         runt_q     <= runt_d;
      end
   end

   assign o_s_tready  = in_ready;
   assign o_m_tvalid  = out_valid;
   assign o_m_tkeep   = out_keep;
   assign o_m_tdata   = mask_data(buf_data_q, out_keep);
   assign o_m_tlast   = out_last;
   assign o_crc       = out_crc;
   assign o_crc_valid = out_valid & i_m_tready & out_last;
   assign o_runt      = runt_q;

endmodule

// File: tb/tb_axi_stream_crc_strip.sv
// Directed self-checking bench for axi_stream_crc_strip at DATA_WIDTH=512.
module tb_axi_stream_crc_strip;

   localparam int unsigned DW = 512;
   localparam int unsigned KB = 64;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          srst = 1'b1;
   logic [DW-1:0] i_s_tdata = '0;
   logic [KB-1:0] i_s_tkeep = '0;
   logic          i_s_tlast = 1'b0;
   logic          i_s_tvalid = 1'b0;
   logic          o_s_tready;
   logic [DW-1:0] o_m_tdata;
   logic [KB-1:0] o_m_tkeep;
   logic          o_m_tlast;
   logic          o_m_tvalid;
   logic          i_m_tready = 1'b1;
   logic [CW-1:0] o_crc;
   logic          o_crc_valid;
   logic          o_runt;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] act_data[$];
   logic [KB-1:0] act_keep[$];
   logic          act_last[$];
   logic          act_cv[$];
   logic [CW-1:0] act_crc[$];
   logic [DW-1:0] exp_data[$];
   logic [KB-1:0] exp_keep[$];
   logic          exp_last[$];
   logic [CW-1:0] exp_crc[$];
   int            runt_seen = 0;
   int            exp_runt  = 0;
   int            stall_chk = 0;
   int            stall_err = 0;
   logic          stalled = 1'b0;
   logic [DW-1:0] st_data;
   logic [KB-1:0] st_keep;
   logic          st_last;
   logic [CW-1:0] st_crc;
   logic          done;

   always #5 clk = ~clk;

   axi_stream_crc_strip dut (
      .clk         (clk),
      .srst        (srst),
      .i_s_tdata   (i_s_tdata),
      .i_s_tkeep   (i_s_tkeep),
      .i_s_tlast   (i_s_tlast),
      .i_s_tvalid  (i_s_tvalid),
      .o_s_tready  (o_s_tready),
      .o_m_tdata   (o_m_tdata),
      .o_m_tkeep   (o_m_tkeep),
      .o_m_tlast   (o_m_tlast),
      .o_m_tvalid  (o_m_tvalid),
      .i_m_tready  (i_m_tready),
      .o_crc       (o_crc),
      .o_crc_valid (o_crc_valid),
      .o_runt      (o_runt)
   );

   // Inputs only change just after posedge, so the negedge view is what transfers
   always @(negedge clk) begin
      if (o_runt) runt_seen++;
      if (stalled && !srst) begin
         stall_chk++;
         if (!o_m_tvalid || o_m_tdata !== st_data || o_m_tkeep !== st_keep ||
             o_m_tlast !== st_last || o_crc !== st_crc) stall_err++;
      end
      if (o_m_tvalid && i_m_tready && !srst) begin
         act_data.push_back(o_m_tdata);
         act_keep.push_back(o_m_tkeep);
         act_last.push_back(o_m_tlast);
         act_cv.push_back(o_crc_valid);
         act_crc.push_back(o_crc);
      end
      stalled = o_m_tvalid && !i_m_tready && !srst;
      st_data = o_m_tdata;
      st_keep = o_m_tkeep;
      st_last = o_m_tlast;
      st_crc  = o_crc;
   end

   function automatic logic [DW-1:0] mkbeat(input int base);
      logic [DW-1:0] d;
      for (int i = 0; i < KB; i++) d[8*i +: 8] = 8'(base + i);
      return d;
   endfunction

   function automatic logic [KB-1:0] kmask(input int n);
      logic [KB-1:0] k;
      for (int i = 0; i < KB; i++) k[i] = (i < n);
      return k;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
      int   cyc;
      logic got;
      i_s_tdata  = d;
      i_s_tkeep  = k;
      i_s_tlast  = l;
      i_s_tvalid = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         got = o_s_tready;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_beat_timeout tready=%b required=1 after %0d cycles", o_s_tready, cyc);
      end
   endtask

   task automatic send_frame(input int nb, input int ln, input int base);
      for (int b = 0; b < nb; b++) begin
         if (b == nb - 1) send_beat(mkbeat(base + 64 * b), kmask(ln), 1'b1);
         else             send_beat(mkbeat(base + 64 * b), '1, 1'b0);
      end
   endtask

   task automatic idle_drain(input int n);
      i_s_tvalid = 1'b0;
      i_s_tlast  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Byte-queue model: drop the last CRC bytes of the frame, re-pack the rest
   task automatic model_frame(input int nb, input int ln, input int base);
      byte unsigned  bq[$];
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [KB-1:0] k;
      int            cnt;
      for (int b = 0; b < nb; b++) begin
         cnt = (b == nb - 1) ? ln : KB;
         for (int i = 0; i < cnt; i++) bq.push_back(8'(base + 64 * b + i));
      end
      if (bq.size() <= 4) begin
         exp_runt++;
         return;
      end
      for (int j = 0; j < 4; j++) c[8*j +: 8] = bq[bq.size() - 4 + j];
      repeat (4) void'(bq.pop_back());
      while (bq.size() > 0) begin
         d = '0;
         k = '0;
         for (int i = 0; i < KB && bq.size() > 0; i++) begin
            d[8*i +: 8] = bq.pop_front();
            k[i] = 1'b1;
         end
         exp_data.push_back(d);
         exp_keep.push_back(k);
         exp_last.push_back(bq.size() == 0);
         exp_crc.push_back((bq.size() == 0) ? c : '0);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (o_m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", o_m_tvalid); end
      total++;
      if (o_crc_valid !== 1'b0) begin bad++; $display("FAIL reset_crc_valid got=%b exp=0", o_crc_valid); end
      total++;
      if (o_runt !== 1'b0) begin bad++; $display("FAIL reset_runt got=%b exp=0", o_runt); end
      total++;
      if (o_crc !== 32'h0) begin bad++; $display("FAIL reset_crc got=%h exp=0", o_crc); end
      srst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (o_s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b exp=1", o_s_tready); end
   endtask

   task automatic test_three_beat;
      logic [DW-1:0] ed[3];
      logic [KB-1:0] ek[3];
      logic          el[3];
      int            s;
      ed[0] = mkbeat(0);  ek[0] = '1;     el[0] = 1'b0;
      ed[1] = mkbeat(64); ek[1] = '1;     el[1] = 1'b0;
      ed[2] = 512'h83828180; ek[2] = 64'hF; el[2] = 1'b1;
      s = act_data.size();
      send_frame(3, 8, 0);
      idle_drain(4);
      total++;
      if (act_data.size() - s != 3) begin
         bad++;
         $display("FAIL three_beat_count got=%0d exp=3", act_data.size() - s);
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (act_data[s+i] !== ed[i] || act_keep[s+i] !== ek[i] || act_last[s+i] !== el[i] ||
                act_cv[s+i] !== el[i]) begin
               bad++;
               $display("FAIL three_beat_%0d keep=%h/%h last=%b/%b cv=%b data=%h exp=%h", i,
                        act_keep[s+i], ek[i], act_last[s+i], el[i], act_cv[s+i], act_data[s+i], ed[i]);
            end
         end
         total++;
         if (act_crc[s+2] !== 32'h87868584) begin
            bad++;
            $display("FAIL three_beat_crc got=%h exp=87868584", act_crc[s+2]);
         end
      end
   endtask

   task automatic test_merge;
      logic [DW-1:0] ed;
      int            s;
      ed = mkbeat(0);
      ed[DW-1 -: 16] = '0;
      s = act_data.size();
      send_frame(2, 2, 0);
      idle_drain(4);
      total++;
      if (act_data.size() - s != 1) begin
         bad++;
         $display("FAIL merge_count got=%0d exp=1", act_data.size() - s);
      end else begin
         total++;
         if (act_keep[s] !== 64'h3FFF_FFFF_FFFF_FFFF || act_last[s] !== 1'b1 || act_cv[s] !== 1'b1) begin
            bad++;
            $display("FAIL merge_ctrl keep=%h exp=3fffffffffffffff last=%b cv=%b exp=1/1",
                     act_keep[s], act_last[s], act_cv[s]);
         end
         total++;
         if (act_data[s] !== ed) begin
            bad++;
            $display("FAIL merge_data got=%h exp=%h", act_data[s], ed);
         end
         total++;
         if (act_crc[s] !== 32'h41403F3E) begin
            bad++;
            $display("FAIL merge_crc got=%h exp=41403f3e", act_crc[s]);
         end
      end
   endtask

   task automatic test_runt;
      int s, r;
      s = act_data.size();
      r = runt_seen;
      send_frame(1, 4, 32);
      idle_drain(4);
      total++;
      if (runt_seen - r != 1) begin bad++; $display("FAIL runt_pulse got=%0d exp=1", runt_seen - r); end
      total++;
      if (act_data.size() - s != 0) begin bad++; $display("FAIL runt_beats got=%0d exp=0", act_data.size() - s); end
      send_frame(1, 5, 16);
      idle_drain(4);
      total++;
      if (act_data.size() - s != 1) begin
         bad++;
         $display("FAIL short_count got=%0d exp=1", act_data.size() - s);
      end else begin
         total++;
         if (act_data[s] !== 512'h10 || act_keep[s] !== 64'h1 || act_last[s] !== 1'b1 || act_cv[s] !== 1'b1) begin
            bad++;
            $display("FAIL short_beat data=%h keep=%h last=%b cv=%b exp data=10 keep=1 last=1 cv=1",
                     act_data[s], act_keep[s], act_last[s], act_cv[s]);
         end
         total++;
         if (act_crc[s] !== 32'h14131211) begin
            bad++;
            $display("FAIL short_crc got=%h exp=14131211", act_crc[s]);
         end
      end
      total++;
      if (runt_seen - r != 1) begin bad++; $display("FAIL short_no_runt got=%0d exp=1", runt_seen - r); end
   endtask

   task automatic test_back_to_back;
      int nb[9] = '{3, 2, 1, 1, 2, 2, 1, 2, 1};
      int ln[9] = '{8, 3, 5, 4, 64, 4, 2, 1, 60};
      int s, es, r, er, sc, se;
      s  = act_data.size();
      es = exp_data.size();
      r  = runt_seen;
      er = exp_runt;
      sc = stall_chk;
      se = stall_err;
      done = 1'b0;
      fork
         begin
            for (int f = 0; f < 9; f++) begin
               model_frame(nb[f], ln[f], 17 * f + 3);
               send_frame(nb[f], ln[f], 17 * f + 3);
            end
            i_s_tvalid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               i_m_tready = ~i_m_tready;
            end
         end
      join
      i_m_tready = 1'b1;
      idle_drain(10);
      total++;
      if (act_data.size() - s != exp_data.size() - es) begin
         bad++;
         $display("FAIL b2b_count got=%0d exp=%0d", act_data.size() - s, exp_data.size() - es);
      end else begin
         for (int i = 0; i < exp_data.size() - es; i++) begin
            total++;
            if (act_data[s+i] !== exp_data[es+i] || act_keep[s+i] !== exp_keep[es+i] ||
                act_last[s+i] !== exp_last[es+i] || act_cv[s+i] !== exp_last[es+i] ||
                (exp_last[es+i] && act_crc[s+i] !== exp_crc[es+i])) begin
               bad++;
               $display("FAIL b2b_beat_%0d keep=%h/%h last=%b/%b cv=%b crc=%h/%h", i,
                        act_keep[s+i], exp_keep[es+i], act_last[s+i], exp_last[es+i],
                        act_cv[s+i], act_crc[s+i], exp_crc[es+i]);
            end
         end
      end
      total++;
      if (runt_seen - r != exp_runt - er) begin
         bad++;
         $display("FAIL b2b_runts got=%0d exp=%0d", runt_seen - r, exp_runt - er);
      end
      total++;
      if (stall_err - se != 0 || stall_chk - sc == 0) begin
         bad++;
         $display("FAIL b2b_stall_stable errors=%0d exp=0 checks=%0d exp>0", stall_err - se, stall_chk - sc);
      end
   endtask

   task automatic test_async_reset;
      int s, es;
      send_beat(mkbeat(85), '1, 1'b0);
      i_m_tready = 1'b0;
      i_s_tdata  = mkbeat(149);
      i_s_tkeep  = '1;
      i_s_tlast  = 1'b0;
      #1;
      total++;
      if (o_m_tvalid !== 1'b1) begin bad++; $display("FAIL hold_tvalid got=%b exp=1", o_m_tvalid); end
      #1;
      srst = 1'b1;
      #1;
      total++;
      if (o_m_tvalid !== 1'b0 || o_crc_valid !== 1'b0 || o_crc !== 32'h0 || o_runt !== 1'b0) begin
         bad++;
         $display("FAIL async_reset tvalid=%b crc_valid=%b crc=%h runt=%b exp=0/0/0/0",
                  o_m_tvalid, o_crc_valid, o_crc, o_runt);
      end
      total++;
      if (o_s_tready !== 1'b1) begin bad++; $display("FAIL async_reset_tready got=%b exp=1", o_s_tready); end
      i_s_tvalid = 1'b0;
      i_m_tready = 1'b1;
      @(posedge clk);
      #1;
      srst = 1'b0;
      @(posedge clk);
      #1;
      s  = act_data.size();
      es = exp_data.size();
      model_frame(2, 6, 144);
      send_frame(2, 6, 144);
      idle_drain(5);
      total++;
      if (act_data.size() - s != exp_data.size() - es) begin
         bad++;
         $display("FAIL post_reset_count got=%0d exp=%0d", act_data.size() - s, exp_data.size() - es);
      end else begin
         for (int i = 0; i < exp_data.size() - es; i++) begin
            total++;
            if (act_data[s+i] !== exp_data[es+i] || act_keep[s+i] !== exp_keep[es+i] ||
                act_last[s+i] !== exp_last[es+i] ||
                (exp_last[es+i] && act_crc[s+i] !== exp_crc[es+i])) begin
               bad++;
               $display("FAIL post_reset_beat_%0d keep=%h/%h last=%b/%b crc=%h/%h", i,
                        act_keep[s+i], exp_keep[es+i], act_last[s+i], exp_last[es+i],
                        act_crc[s+i], exp_crc[es+i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_three_beat();
      test_merge();
      test_runt();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
